// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: branch flush, multiply interlock, load-use stall, operand forwarding
module hazard_ctrl #(
  parameter int unsigned MUL_LAT    = 3,
  parameter int unsigned BR_PENALTY = 2,
  parameter int unsigned FWD_EN     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ir1_i,
  input  logic [31:0] ir2_i,
  input  logic [31:0] ir3_i,
  input  logic [31:0] ir4_i,
  output logic        stall_pc_o,
  output logic        stall_ifid_o,
  output logic        stall_idex_o,
  output logic        flush_ifid_o,
  output logic        bubble_idex_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        busy_o
);

  localparam logic [3:0] OP_LW    = 4'd0;
  localparam logic [3:0] OP_SW    = 4'd1;
  localparam logic [3:0] OP_LI    = 4'd2;
  localparam logic [3:0] OP_ADDU  = 4'd3;
  localparam logic [3:0] OP_ADDIU = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_MUL   = 4'd6;
  localparam logic [3:0] OP_BGE   = 4'd7;
  localparam logic [3:0] OP_J     = 4'd8;
  localparam logic [3:0] OP_MULI  = 4'd9;

  localparam logic       FWD         = (FWD_EN != 0);
  localparam logic       MUL_STALLS  = (MUL_LAT > 1);
  localparam logic       BR_MULTI    = (BR_PENALTY > 1);
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 2);
  localparam logic [3:0] BR_CNT_INIT  = 4'(BR_PENALTY - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    BR_WAIT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  // Opcode writes its rd field.
  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      OP_LW, OP_LI, OP_ADDU, OP_ADDIU, OP_SLL, OP_MUL, OP_MULI: writes_rd = 1'b1;
      default:                                                  writes_rd = 1'b0;
    endcase
  endfunction

  // Operand A source as {valid, register}; register 0 is never a valid source.
  function automatic logic [5:0] src_a_of(input logic [3:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs);
    logic [4:0] r;
    r = 5'd0;
    case (op)
      OP_LW, OP_ADDU, OP_ADDIU, OP_SLL, OP_MUL, OP_MULI: r = rs;
      OP_SW, OP_BGE:                                     r = rd;
      default:                                           r = 5'd0;
    endcase
    src_a_of = {(r != 5'd0), r};
  endfunction

  // Operand B source as {valid, register}.
  function automatic logic [5:0] src_b_of(input logic [3:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
    logic [4:0] r;
    r = 5'd0;
    case (op)
      OP_SW, OP_BGE:   r = rs;
      OP_ADDU, OP_MUL: r = rt;
      default:         r = 5'd0;
    endcase
    src_b_of = {(r != 5'd0), r};
  endfunction

  function automatic logic src_hits(input logic [5:0] src, input logic wr, input logic [4:0] rd);
    src_hits = src[5] && wr && (src[4:0] == rd);
  endfunction

  // Nearest producer wins: EX/MEM before MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [5:0] src,
                                         input logic ex_ok, input logic [4:0] ex_rd,
                                         input logic wb_ok, input logic [4:0] wb_rd);
    if (src_hits(src, ex_ok, ex_rd))      fwd_sel = 2'b01;
    else if (src_hits(src, wb_ok, wb_rd)) fwd_sel = 2'b10;
    else                                  fwd_sel = 2'b00;
  endfunction

  logic [3:0] op1, op2, op3, op4;
  logic [4:0] rd1, rd2, rd3, rd4;
  logic [4:0] rs1, rs2, rt1, rt2;
  logic       wr2, wr3, wr4;
  logic [5:0] a1, b1, a2, b2;
  logic       dep_ir2, dep_ir3;
  logic       is_branch, is_mul, load_use;
  logic       ex_fwd_ok;
  logic       unused_bits;

  assign op1 = ir1_i[31:28];
  assign op2 = ir2_i[31:28];
  assign op3 = ir3_i[31:28];
  assign op4 = ir4_i[31:28];
  assign rd1 = ir1_i[27:23];
  assign rd2 = ir2_i[27:23];
  assign rd3 = ir3_i[27:23];
  assign rd4 = ir4_i[27:23];
  assign rs1 = ir1_i[22:18];
  assign rs2 = ir2_i[22:18];
  assign rt1 = ir1_i[17:13];
  assign rt2 = ir2_i[17:13];

  assign unused_bits = ^{ir1_i[12:0], ir2_i[12:0], ir3_i[22:0], ir4_i[22:0]};

  // A writer to r0 produces nothing anyone can depend on.
  assign wr2 = writes_rd(op2) && (rd2 != 5'd0);
  assign wr3 = writes_rd(op3) && (rd3 != 5'd0);
  assign wr4 = writes_rd(op4) && (rd4 != 5'd0);

  assign a1 = src_a_of(op1, rd1, rs1);
  assign b1 = src_b_of(op1, rs1, rt1);
  assign a2 = src_a_of(op2, rd2, rs2);
  assign b2 = src_b_of(op2, rs2, rt2);

  assign dep_ir2 = src_hits(a1, wr2, rd2) || src_hits(b1, wr2, rd2);
  assign dep_ir3 = src_hits(a1, wr3, rd3) || src_hits(b1, wr3, rd3);

  assign is_branch = (op2 == OP_BGE) || (op2 == OP_J);
  assign is_mul    = (op2 == OP_MUL) || (op2 == OP_MULI);

  // Load data is not available from EX/MEM; without forwarding any in-flight producer blocks ID.
  assign load_use = ((op2 == OP_LW) && dep_ir2) ||
                    (!FWD && (dep_ir2 || dep_ir3));

  // A load in EX/MEM has no result yet, so it can only be forwarded once it reaches MEM/WB.
  assign ex_fwd_ok = wr3 && (op3 != OP_LW);

  logic stall_pc, stall_ifid, stall_idex, flush_ifid, bubble_idex;

  // State and counter register; reset always returns to RUN with an idle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and control outputs, in priority order: multiply wait, branch, multiply start, load-use.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    case (state)
      MUL_BUSY: begin
        if (cnt != 4'd0) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          cnt_next   = cnt - 4'd1;
        end else begin
          state_next = RUN;
        end
      end
      BR_WAIT: begin
        stall_pc   = 1'b1;
        flush_ifid = 1'b1;
        cnt_next   = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_next = RUN;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        if (is_branch) begin
          stall_pc   = 1'b1;
          flush_ifid = 1'b1;
          if (BR_MULTI) begin
            state_next = BR_WAIT;
            cnt_next   = BR_CNT_INIT;
          end
        end else if (is_mul && MUL_STALLS) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          state_next = MUL_BUSY;
          cnt_next   = MUL_CNT_INIT;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end
      end
    endcase
  end

  assign stall_pc_o    = stall_pc    & ~rst_i;
  assign stall_ifid_o  = stall_ifid  & ~rst_i;
  assign stall_idex_o  = stall_idex  & ~rst_i;
  assign flush_ifid_o  = flush_ifid  & ~rst_i;
  assign bubble_idex_o = bubble_idex & ~rst_i;
  assign busy_o        = (state != RUN) & ~rst_i;

  assign fwd_a_o = (FWD && !rst_i) ? fwd_sel(a2, ex_fwd_ok, rd3, wr4, rd4) : 2'b00;
  assign fwd_b_o = (FWD && !rst_i) ? fwd_sel(b2, ex_fwd_ok, rd3, wr4, rd4) : 2'b00;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a cycle-count model
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir1, ir2, ir3, ir4;

  logic a_stall_pc, a_stall_ifid, a_stall_idex, a_flush, a_bubble, a_busy;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic b_stall_pc, b_stall_ifid, b_stall_idex, b_flush, b_bubble, b_busy;
  logic [1:0] b_fwd_a, b_fwd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Configuration A: forwarding, long multiply, 3-cycle branch penalty.
  hazard_ctrl #(.MUL_LAT(4), .BR_PENALTY(3), .FWD_EN(1)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .ir1_i(ir1), .ir2_i(ir2), .ir3_i(ir3), .ir4_i(ir4),
    .stall_pc_o(a_stall_pc), .stall_ifid_o(a_stall_ifid), .stall_idex_o(a_stall_idex),
    .flush_ifid_o(a_flush), .bubble_idex_o(a_bubble),
    .fwd_a_o(a_fwd_a), .fwd_b_o(a_fwd_b), .busy_o(a_busy)
  );

  // Configuration B: interlock only, short multiply, single-cycle branch penalty.
  hazard_ctrl #(.MUL_LAT(2), .BR_PENALTY(1), .FWD_EN(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .ir1_i(ir1), .ir2_i(ir2), .ir3_i(ir3), .ir4_i(ir4),
    .stall_pc_o(b_stall_pc), .stall_ifid_o(b_stall_ifid), .stall_idex_o(b_stall_idex),
    .flush_ifid_o(b_flush), .bubble_idex_o(b_bubble),
    .fwd_a_o(b_fwd_a), .fwd_b_o(b_fwd_b), .busy_o(b_busy)
  );

  typedef struct packed {
    logic       stall_pc;
    logic       stall_ifid;
    logic       stall_idex;
    logic       flush;
    logic       bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       busy;
  } out_t;

  // Model state is just the number of cycles still owed to a multiply or a branch.
  typedef struct {
    int mul_lat;
    int br_pen;
    bit fwd_en;
    int mul_rem;
    int br_rem;
  } mdl_t;

  mdl_t m_a = '{mul_lat: 4, br_pen: 3, fwd_en: 1'b1, mul_rem: 0, br_rem: 0};
  mdl_t m_b = '{mul_lat: 2, br_pen: 1, fwd_en: 1'b0, mul_rem: 0, br_rem: 0};

  logic [9:0] a_act, b_act;
  assign a_act = {a_stall_pc, a_stall_ifid, a_stall_idex, a_flush, a_bubble, a_fwd_a, a_fwd_b, a_busy};
  assign b_act = {b_stall_pc, b_stall_ifid, b_stall_idex, b_flush, b_bubble, b_fwd_a, b_fwd_b, b_busy};

  localparam logic [31:0] NOP = 32'hF000_0000;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    mk = {op, rd, rs, rt, 13'd0};
  endfunction

  function automatic int opc(input logic [31:0] ir);
    opc = int'(ir[31:28]);
  endfunction

  function automatic int dest(input logic [31:0] ir);
    if (opc(ir) inside {0, 2, 3, 4, 5, 6, 9}) dest = int'(ir[27:23]);
    else dest = 0;
  endfunction

  function automatic int srca(input logic [31:0] ir);
    if (opc(ir) inside {0, 3, 4, 5, 6, 9}) srca = int'(ir[22:18]);
    else if (opc(ir) inside {1, 7})        srca = int'(ir[27:23]);
    else                                   srca = 0;
  endfunction

  function automatic int srcb(input logic [31:0] ir);
    if (opc(ir) inside {1, 7})      srcb = int'(ir[22:18]);
    else if (opc(ir) inside {3, 6}) srcb = int'(ir[17:13]);
    else                            srcb = 0;
  endfunction

  function automatic logic [1:0] fwd_of(input int r, input logic [31:0] i3, input logic [31:0] i4);
    if (r == 0)                              fwd_of = 2'b00;
    else if (opc(i3) != 0 && dest(i3) == r)  fwd_of = 2'b01;
    else if (dest(i4) == r)                  fwd_of = 2'b10;
    else                                     fwd_of = 2'b00;
  endfunction

  function automatic bit depends(input logic [31:0] consumer, input logic [31:0] producer);
    int d;
    d = dest(producer);
    depends = (d != 0) && (srca(consumer) == d || srcb(consumer) == d);
  endfunction

  function automatic out_t expect_out(input mdl_t m, input logic r,
                                      input logic [31:0] i1, input logic [31:0] i2,
                                      input logic [31:0] i3, input logic [31:0] i4);
    out_t o;
    bit lu;
    o = '0;
    if (r) return o;
    if (m.fwd_en) begin
      o.fwd_a = fwd_of(srca(i2), i3, i4);
      o.fwd_b = fwd_of(srcb(i2), i3, i4);
    end
    lu = (opc(i2) == 0 && depends(i1, i2)) ||
         (!m.fwd_en && (depends(i1, i2) || depends(i1, i3)));
    if (m.mul_rem > 0) begin
      o.busy = 1'b1;
      if (m.mul_rem > 1) {o.stall_pc, o.stall_ifid, o.stall_idex} = 3'b111;
    end else if (m.br_rem > 0) begin
      o.busy = 1'b1;
      {o.stall_pc, o.flush} = 2'b11;
    end else if (opc(i2) inside {7, 8}) begin
      {o.stall_pc, o.flush} = 2'b11;
    end else if (opc(i2) inside {6, 9} && m.mul_lat > 1) begin
      {o.stall_pc, o.stall_ifid, o.stall_idex} = 3'b111;
    end else if (lu) begin
      {o.stall_pc, o.stall_ifid, o.bubble} = 3'b111;
    end
    return o;
  endfunction

  function automatic mdl_t advance(input mdl_t m, input logic r, input logic [31:0] i2);
    mdl_t n;
    n = m;
    if (r) begin
      n.mul_rem = 0;
      n.br_rem  = 0;
    end else if (m.mul_rem > 0) begin
      n.mul_rem = m.mul_rem - 1;
    end else if (m.br_rem > 0) begin
      n.br_rem = m.br_rem - 1;
    end else if (opc(i2) inside {7, 8}) begin
      n.br_rem = m.br_pen - 1;
    end else if (opc(i2) inside {6, 9} && m.mul_lat > 1) begin
      n.mul_rem = m.mul_lat - 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (stall_pc,ifid,idex,flush,bubble,fwd_a,fwd_b,busy)",
               name, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] i1, input logic [31:0] i2,
                     input logic [31:0] i3, input logic [31:0] i4);
    @(posedge clk);
    #1;
    rst = r;
    ir1 = i1;
    ir2 = i2;
    ir3 = i3;
    ir4 = i4;
    #1;
  endtask

  // Compare both designs against the model on every falling edge, then step the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk($sformatf("dut_a t=%0t", $time), a_act, expect_out(m_a, rst, ir1, ir2, ir3, ir4));
      chk($sformatf("dut_b t=%0t", $time), b_act, expect_out(m_b, rst, ir1, ir2, ir3, ir4));
      m_a = advance(m_a, rst, ir2);
      m_b = advance(m_b, rst, ir2);
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    ir1 = NOP; ir2 = NOP; ir3 = NOP; ir4 = NOP;

    // Reset with a jump in ir2: nothing may come out.
    cyc(1, NOP, mk(8, 0, 0, 0), NOP, NOP);
    lit("reset_flush", {3'b0, a_flush}, 4'b0000);
    lit("reset_busy", {3'b0, a_busy}, 4'b0000);
    cyc(1, NOP, mk(8, 0, 0, 0), NOP, NOP);
    lit("reset_all_b", {b_stall_pc, b_flush, b_bubble, b_busy}, 4'b0000);

    // ADDU r3<-r1,r2 then ADDU r5<-r3,r4.
    cyc(0, mk(3, 5, 3, 4), mk(3, 3, 1, 2), NOP, NOP);
    lit("fwd_nostall_a", {a_stall_pc, a_stall_ifid, a_bubble, 1'b0}, 4'b0000);
    lit("nofwd_stall_b", {b_stall_pc, b_stall_ifid, b_bubble, 1'b0}, 4'b1110);
    cyc(0, NOP, mk(3, 5, 3, 4), mk(3, 3, 1, 2), NOP);
    lit("fwd_a_exmem", {2'b00, a_fwd_a}, 4'b0001);
    lit("fwd_a_off_b", {2'b00, b_fwd_a}, 4'b0000);
    // LW in EX/MEM is skipped; the older ADDU in MEM/WB supplies operand B.
    cyc(0, NOP, mk(3, 6, 7, 3), mk(0, 3, 1, 0), mk(3, 3, 1, 2));
    lit("fwd_b_memwb", {a_fwd_a, a_fwd_b}, 4'b0010);

    // LW r4 followed by SW with rd=r4.
    cyc(0, mk(1, 4, 1, 0), mk(0, 4, 2, 0), NOP, NOP);
    lit("load_use_on", {a_stall_pc, a_stall_ifid, a_bubble, a_stall_idex}, 4'b1110);
    cyc(0, mk(1, 4, 1, 0), NOP, mk(0, 4, 2, 0), NOP);
    lit("load_use_off", {a_stall_pc, a_stall_ifid, a_bubble, a_stall_idex}, 4'b0000);
    lit("nofwd_ir3_b", {b_stall_pc, b_stall_ifid, b_bubble, 1'b0}, 4'b1110);

    // BGE in ir2 while ir1 depends on an in-flight producer: branch response only.
    cyc(0, mk(1, 4, 1, 0), mk(7, 1, 2, 0), mk(0, 4, 2, 0), NOP);
    lit("br_only_a", {a_stall_pc, a_stall_ifid, a_flush, a_bubble}, 4'b1010);
    lit("br_only_b", {b_stall_pc, b_stall_ifid, b_flush, b_bubble}, 4'b1010);
    cyc(0, NOP, NOP, NOP, NOP);
    lit("br_wait_a", {a_stall_pc, a_flush, a_busy, 1'b0}, 4'b1110);
    lit("br_pen1_b", {b_stall_pc, b_flush, b_busy, 1'b0}, 4'b0000);
    cyc(0, NOP, NOP, NOP, NOP);
    cyc(0, NOP, NOP, NOP, NOP);
    lit("br_done_a", {a_stall_pc, a_flush, a_busy, 1'b0}, 4'b0000);

    // Register 0 never creates a dependency or a forward.
    cyc(0, mk(3, 3, 0, 0), mk(3, 0, 1, 2), NOP, NOP);
    lit("r0_nostall_b", {b_stall_pc, b_bubble, 2'b00}, 4'b0000);
    cyc(0, NOP, mk(3, 4, 0, 5), mk(3, 0, 1, 2), mk(3, 0, 1, 2));
    lit("r0_nofwd_a", {a_fwd_a, a_fwd_b}, 4'b0000);

    // MUL held in ir2: three stall cycles, busy on cycles 2..4.
    cyc(0, NOP, mk(6, 7, 1, 2), NOP, NOP);
    lit("mul_c1", {a_stall_pc, a_stall_ifid, a_stall_idex, a_busy}, 4'b1110);
    cyc(0, NOP, mk(6, 7, 1, 2), NOP, NOP);
    lit("mul_c2", {a_stall_pc, a_stall_ifid, a_stall_idex, a_busy}, 4'b1111);
    cyc(0, NOP, mk(6, 7, 1, 2), NOP, NOP);
    lit("mul_c3", {a_stall_pc, a_stall_ifid, a_stall_idex, a_busy}, 4'b1111);
    cyc(0, NOP, mk(6, 7, 1, 2), NOP, NOP);
    lit("mul_c4", {a_stall_pc, a_stall_ifid, a_stall_idex, a_busy}, 4'b0001);
    cyc(0, NOP, NOP, mk(6, 7, 1, 2), NOP);
    lit("mul_done", {a_stall_pc, a_stall_ifid, a_stall_idex, a_busy}, 4'b0000);

    // J with a three-cycle penalty.
    cyc(0, NOP, mk(8, 0, 0, 0), NOP, NOP);
    lit("j_c1", {a_stall_pc, a_flush, a_busy, 1'b0}, 4'b1100);
    cyc(0, NOP, NOP, NOP, NOP);
    lit("j_c2", {a_stall_pc, a_flush, a_busy, 1'b0}, 4'b1110);
    cyc(0, NOP, NOP, NOP, NOP);
    lit("j_c3", {a_stall_pc, a_flush, a_busy, 1'b0}, 4'b1110);
    cyc(0, NOP, NOP, NOP, NOP);
    lit("j_after", {a_stall_pc, a_flush, a_busy, 1'b0}, 4'b0000);

    // Reset pulse in the middle of a branch wait.
    cyc(0, NOP, mk(8, 0, 0, 0), NOP, NOP);
    cyc(1, NOP, NOP, NOP, NOP);
    lit("rst_br_out", {a_stall_pc, a_flush, a_busy, a_stall_ifid}, 4'b0000);
    cyc(0, NOP, NOP, NOP, NOP);
    lit("rst_br_after", {a_stall_pc, a_flush, a_busy, 1'b0}, 4'b0000);

    // Reset pulse in the middle of a multiply wait.
    cyc(0, NOP, mk(6, 7, 1, 2), NOP, NOP);
    cyc(1, NOP, mk(6, 7, 1, 2), NOP, NOP);
    lit("rst_mul_out", {a_stall_pc, a_stall_idex, a_busy, 1'b0}, 4'b0000);
    cyc(0, NOP, NOP, NOP, NOP);
    lit("rst_mul_after", {a_stall_pc, a_stall_idex, a_busy, 1'b0}, 4'b0000);

    // MULI also starts the multiply interlock.
    cyc(0, NOP, mk(9, 8, 1, 0), NOP, NOP);
    lit("muli_c1", {a_stall_pc, a_stall_idex, a_busy, 1'b0}, 4'b1100);
    cyc(0, NOP, NOP, NOP, NOP);
    lit("muli_c2", {a_stall_pc, a_stall_idex, a_busy, 1'b0}, 4'b1110);

    // Mixed traffic over a small register set, checked against the model only.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          mk(4'($urandom_range(0, 15)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
          mk(4'($urandom_range(0, 15)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
          mk(4'($urandom_range(0, 15)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
          mk(4'($urandom_range(0, 15)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
